hazard_scoreboard_unit: RTL and testbench

//  Parametrised stall/forward controller for the 5-stage (F/D/E/M/W) pipeline.
//  - Keeps its own shadow copy of the write address, write enable and Tnew for E/M/W.
//  - Decides stall/bubble from Tuse/Tnew and the forward mux selects for D, E and M.
//  - Owns the mult/div busy timer.
//  - Datapath feeds D-stage decode info only; this unit tracks downstream stages itself.

---
 rtl/hazard_scoreboard_unit_pkg.sv | 19 +
 rtl/hazard_scoreboard_unit_if.sv | 39 +++
 rtl/hazard_scoreboard_unit_md_busy_timer.sv | 31 +++
 rtl/hazard_scoreboard_unit.sv | 149 ++++++++++++++
 tb/tb_hazard_scoreboard_unit.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/hazard_scoreboard_unit_pkg.sv
// Shared constants for the hazard scoreboard unit.
//   fwd_sel_e : encoding of the forward mux selects driven to the datapath
//   DEF_*     : default geometry and mult/div latencies
package hazard_scoreboard_unit_pkg;

    typedef enum logic [1:0] {
        FWD_RF = 2'd0,  // register file / pipeline register value
        FWD_E  = 2'd1,  // E-stage result
        FWD_M  = 2'd2,  // M-stage result
        FWD_W  = 2'd3   // W-stage result
    } fwd_sel_e;

    localparam int DEF_NREAD       = 2;
    localparam int DEF_AW          = 5;
    localparam int DEF_TW          = 3;
    localparam int DEF_MULT_CYCLES = 5;
    localparam int DEF_DIV_CYCLES  = 10;

endpackage

// File: rtl/hazard_scoreboard_unit_if.sv
// D-stage decode info in, stall/forward controls out.
//   master : datapath side (drives decode info, consumes controls)
//   slave  : hazard scoreboard side
// raddr_D / tuse_D pack read port i at [i*AW +: AW] / [i*TW +: TW];
// fwd_*_sel pack port i at [2*i +: 2].
interface hazard_scoreboard_unit_if #(
    parameter int NREAD = 2,
    parameter int AW    = 5,
    parameter int TW    = 3
);
    logic                  valid_D;
    logic [NREAD*AW-1:0]   raddr_D;
    logic [NREAD*TW-1:0]   tuse_D;
    logic [AW-1:0]         waddr_D;
    logic                  we_D;
    logic [TW-1:0]         tnew_D;
    logic                  md_start_D;
    logic                  md_div_D;
    logic                  md_use_D;
    logic                  stall_F;
    logic                  stall_D;
    logic                  flush_E;
    logic [2*NREAD-1:0]    fwd_D_sel;
    logic [2*NREAD-1:0]    fwd_E_sel;
    logic                  fwd_M_sel;
    logic                  md_busy;

    modport master (
        output valid_D, raddr_D, tuse_D, waddr_D, we_D, tnew_D,
               md_start_D, md_div_D, md_use_D,
        input  stall_F, stall_D, flush_E, fwd_D_sel, fwd_E_sel, fwd_M_sel, md_busy
    );

    modport slave (
        input  valid_D, raddr_D, tuse_D, waddr_D, we_D, tnew_D,
               md_start_D, md_div_D, md_use_D,
        output stall_F, stall_D, flush_E, fwd_D_sel, fwd_E_sel, fwd_M_sel, md_busy
    );
endinterface

// File: rtl/hazard_scoreboard_unit_md_busy_timer.sv
// Mult/div busy down-counter.
//   clk, reset : clock, synchronous active-high reset
//   load       : load load_val this cycle (wins over the decrement)
//   load_val   : cycle count for the operation just started
//   busy       : counter nonzero
module hazard_scoreboard_unit_md_busy_timer #(
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    output logic          busy
);
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load)
            cnt_d = load_val;
        else if (cnt_q != '0)
            cnt_d = cnt_q - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign busy = (cnt_q != '0);
endmodule

// File: rtl/hazard_scoreboard_unit.sv
// Stall/forward controller for the F/D/E/M/W pipeline.
//   clk, reset : clock, synchronous active-high reset
//   hif        : slave side of hazard_scoreboard_unit_if (D decode info in,
//                stall_F/stall_D/flush_E, forward selects and md_busy out)
// Shadows dest/we/Tnew of E, M, W from the D-stage info it is fed, so the
// datapath only has to present the instruction currently in D.
module hazard_scoreboard_unit
    import hazard_scoreboard_unit_pkg::*;
#(
    parameter int NREAD       = DEF_NREAD,
    parameter int AW          = DEF_AW,
    parameter int TW          = DEF_TW,
    parameter int MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
    input logic                     clk,
    input logic                     reset,
    hazard_scoreboard_unit_if.slave hif
);
    localparam int SP    = (NREAD > 1) ? 1 : 0;  // store-data read port
    localparam int MDMAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW    = $clog2(MDMAX + 1);

    logic [NREAD-1:0][AW-1:0] raddr_v;
    logic [NREAD-1:0][TW-1:0] tuse_v;
    logic [NREAD-1:0][1:0]    fwd_d_v, fwd_e_v;
    logic [NREAD-1:0]         port_stall;
    logic                     data_stall, md_stall, stall, adv, md_busy;

    // shadow pipeline
    logic                     we_e_q, we_e_d, md_start_e_q, md_start_e_d, md_div_e_q, md_div_e_d;
    logic [AW-1:0]            waddr_e_q, waddr_e_d;
    logic [TW-1:0]            tnew_e_q, tnew_e_d;
    logic [NREAD-1:0][AW-1:0] raddr_e_q, raddr_e_d;
    logic                     we_m_q, we_m_d;
    logic [AW-1:0]            waddr_m_q, waddr_m_d, raddr1_m_q, raddr1_m_d;
    logic [TW-1:0]            tnew_m_q, tnew_m_d;
    logic                     we_w_q, we_w_d;
    logic [AW-1:0]            waddr_w_q, waddr_w_d;

    assign raddr_v = hif.raddr_D;
    assign tuse_v  = hif.tuse_D;

    for (genvar i = 0; i < NREAD; i++) begin : g_port
        logic       nz_d, m_e, m_m, m_w, used, stl;
        logic       nz_e, em_m, em_w;
        logic [1:0] fd, fe;

        assign nz_d = (raddr_v[i] != '0);
        assign m_e  = we_e_q && (waddr_e_q == raddr_v[i]) && nz_d;
        assign m_m  = we_m_q && (waddr_m_q == raddr_v[i]) && nz_d;
        assign m_w  = we_w_q && (waddr_w_q == raddr_v[i]) && nz_d;
        assign used = (tuse_v[i] != '1);

        // Only the nearest producer counts; W data is final, so a W match
        // never stalls and always forwards.
        always_comb begin
            stl = 1'b0;
            fd  = FWD_RF;
            if (m_e) begin
                stl = used && (tnew_e_q > tuse_v[i]);
                if (tnew_e_q == '0) fd = FWD_E;
            end else if (m_m) begin
                stl = used && (tnew_m_q > tuse_v[i]);
                if (tnew_m_q == '0) fd = FWD_M;
            end else if (m_w) begin
                fd = FWD_W;
            end
        end

        assign nz_e = (raddr_e_q[i] != '0);
        assign em_m = we_m_q && (waddr_m_q == raddr_e_q[i]) && nz_e;
        assign em_w = we_w_q && (waddr_w_q == raddr_e_q[i]) && nz_e;
        assign fe   = em_m ? FWD_M : (em_w ? FWD_W : FWD_RF);

        assign port_stall[i] = stl;
        assign fwd_d_v[i]    = fd;
        assign fwd_e_v[i]    = fe;
    end

    assign data_stall = hif.valid_D && (|port_stall);
    // The start sits in E one cycle before the timer is loaded; the
    // md_start_e_q term covers that gap.
    assign md_stall   = hif.valid_D && hif.md_use_D && (md_busy || md_start_e_q);
    assign stall      = data_stall || md_stall;
    assign adv        = hif.valid_D && !stall;

    always_comb begin
        we_e_d       = adv && hif.we_D;
        waddr_e_d    = adv ? hif.waddr_D : '0;
        tnew_e_d     = adv ? hif.tnew_D : '0;
        raddr_e_d    = adv ? raddr_v : '0;
        md_start_e_d = adv && hif.md_start_D;
        md_div_e_d   = adv && hif.md_div_D;
        we_m_d       = we_e_q;
        waddr_m_d    = waddr_e_q;
        tnew_m_d     = (tnew_e_q != '0) ? tnew_e_q - TW'(1) : '0;
        raddr1_m_d   = raddr_e_q[SP];
        we_w_d       = we_m_q;
        waddr_w_d    = waddr_m_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            we_e_q       <= 1'b0;
            waddr_e_q    <= '0;
            tnew_e_q     <= '0;
            raddr_e_q    <= '0;
            md_start_e_q <= 1'b0;
            md_div_e_q   <= 1'b0;
            we_m_q       <= 1'b0;
            waddr_m_q    <= '0;
            tnew_m_q     <= '0;
            raddr1_m_q   <= '0;
            we_w_q       <= 1'b0;
            waddr_w_q    <= '0;
        end else begin
            we_e_q       <= we_e_d;
            waddr_e_q    <= waddr_e_d;
            tnew_e_q     <= tnew_e_d;
            raddr_e_q    <= raddr_e_d;
            md_start_e_q <= md_start_e_d;
            md_div_e_q   <= md_div_e_d;
            we_m_q       <= we_m_d;
            waddr_m_q    <= waddr_m_d;
            tnew_m_q     <= tnew_m_d;
            raddr1_m_q   <= raddr1_m_d;
            we_w_q       <= we_w_d;
            waddr_w_q    <= waddr_w_d;
        end
    end

    // Timer starts counting once the start has reached E.
    hazard_scoreboard_unit_md_busy_timer #(.CW(CW)) u_md_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (md_start_e_q),
        .load_val (md_div_e_q ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES)),
        .busy     (md_busy)
    );

    assign hif.stall_F   = stall;
    assign hif.stall_D   = stall;
    assign hif.flush_E   = stall;
    assign hif.fwd_D_sel = fwd_d_v;
    assign hif.fwd_E_sel = fwd_e_v;
    assign hif.fwd_M_sel = we_w_q && (waddr_w_q == raddr1_m_q) && (raddr1_m_q != '0);
    assign hif.md_busy   = md_busy;
endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
module tb_hazard_scoreboard_unit;
    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    hazard_scoreboard_unit_if #(.NREAD(2), .AW(5), .TW(3)) hif ();

    hazard_scoreboard_unit #(
        .NREAD(2), .AW(5), .TW(3), .MULT_CYCLES(5), .DIV_CYCLES(10)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .hif   (hif)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic st, input logic [3:0] fd,
                           input logic [3:0] fe, input logic fm, input logic busy);
        chk({tag, ".stall_F"}, 32'(hif.stall_F), 32'(st));
        chk({tag, ".stall_D"}, 32'(hif.stall_D), 32'(st));
        chk({tag, ".flush_E"}, 32'(hif.flush_E), 32'(st));
        chk({tag, ".fwd_D"},   32'(hif.fwd_D_sel), 32'(fd));
        chk({tag, ".fwd_E"},   32'(hif.fwd_E_sel), 32'(fe));
        chk({tag, ".fwd_M"},   32'(hif.fwd_M_sel), 32'(fm));
        chk({tag, ".md_busy"}, 32'(hif.md_busy), 32'(busy));
    endtask

    // D-stage instruction: rs/tuse0, rt/tuse1, dest/we/tnew, md flags
    task automatic drv(input logic v, input logic [4:0] rs, input logic [2:0] tu0,
                       input logic [4:0] rt, input logic [2:0] tu1,
                       input logic [4:0] wa, input logic we, input logic [2:0] tn,
                       input logic ms, input logic md, input logic mu);
        hif.valid_D    = v;
        hif.raddr_D    = {rt, rs};
        hif.tuse_D     = {tu1, tu0};
        hif.waddr_D    = wa;
        hif.we_D       = we;
        hif.tnew_D     = tn;
        hif.md_start_D = ms;
        hif.md_div_D   = md;
        hif.md_use_D   = mu;
        #1;
    endtask

    task automatic nop();
        drv(1'b0, 5'd0, 3'd7, 5'd0, 3'd7, 5'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic flush();
        nop();
        repeat (3) adv();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // reset with a hazard-looking D instruction present
        reset = 1'b1;
        drv(1'b1, 5'd9, 3'd0, 5'd9, 3'd0, 5'd9, 1'b1, 3'd2, 1'b1, 1'b1, 1'b1);
        adv(); adv();
        chk_all("reset", 1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
        reset = 1'b0;
        flush();

        // lw $9 ; add $10,$9,$9 -> one stall, then W forward at E on both ports
        drv(1'b1, 5'd29, 3'd1, 5'd0, 3'd7, 5'd9, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0);
        chk_all("lw.D", 1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
        adv();
        drv(1'b1, 5'd9, 3'd1, 5'd9, 3'd1, 5'd10, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0);
        chk_all("add.stall", 1'b1, 4'h0, 4'h0, 1'b0, 1'b0);
        adv();
        chk_all("add.go", 1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
        adv();
        nop();
        chk_all("add.E", 1'b0, 4'h0, 4'hF, 1'b0, 1'b0);
        flush();

        // jal ; beq $31,$0 -> E forward, then M forward when still in D
        drv(1'b1, 5'd0, 3'd7, 5'd0, 3'd7, 5'd31, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0);
        adv();
        drv(1'b1, 5'd31, 3'd0, 5'd0, 3'd0, 5'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        chk_all("beq.fwdE", 1'b0, 4'h1, 4'h0, 1'b0, 1'b0);
        adv();
        chk_all("beq.fwdM", 1'b0, 4'h2, 4'h2, 1'b0, 1'b0);
        flush();

        // lw $31 ; jal ; beq $31 -> nearer jal wins, older lw ignored
        drv(1'b1, 5'd29, 3'd1, 5'd0, 3'd7, 5'd31, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0);
        adv();
        drv(1'b1, 5'd0, 3'd7, 5'd0, 3'd7, 5'd31, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0);
        adv();
        drv(1'b1, 5'd31, 3'd0, 5'd0, 3'd0, 5'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        chk_all("near.E", 1'b0, 4'h1, 4'h0, 1'b0, 1'b0);
        adv();
        chk_all("near.M", 1'b0, 4'h2, 4'h2, 1'b0, 1'b0);
        flush();

        // lw $9 ; addu $3 ; beq $9 -> stall on M match, then W forward in D
        drv(1'b1, 5'd29, 3'd1, 5'd0, 3'd7, 5'd9, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0);
        adv();
        drv(1'b1, 5'd1, 3'd1, 5'd2, 3'd1, 5'd3, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0);
        adv();
        drv(1'b1, 5'd9, 3'd0, 5'd0, 3'd0, 5'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        chk_all("mstall", 1'b1, 4'h0, 4'h0, 1'b0, 1'b0);
        adv();
        chk_all("mstall.W", 1'b0, 4'h3, 4'h0, 1'b0, 1'b0);
        flush();

        // lw $8 ; sw $8 -> no stall (tuse 2), store data forwarded at M from W
        drv(1'b1, 5'd29, 3'd1, 5'd0, 3'd7, 5'd8, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0);
        adv();
        drv(1'b1, 5'd29, 3'd1, 5'd8, 3'd2, 5'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        chk_all("sw.D", 1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
        adv();
        nop();
        adv();
        chk({"sw.M", ".fwd_M"}, 32'(hif.fwd_M_sel), 32'd1);
        flush();

        // addu $0 ; user of $0 -> never matches
        drv(1'b1, 5'd1, 3'd1, 5'd2, 3'd1, 5'd0, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0);
        adv();
        drv(1'b1, 5'd0, 3'd0, 5'd0, 3'd0, 5'd4, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0);
        chk_all("r0.a", 1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
        adv();
        chk_all("r0.b", 1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
        flush();

        // mult ; mflo -> 1 cycle start-in-E + 5 busy cycles of stall
        drv(1'b1, 5'd4, 3'd1, 5'd5, 3'd1, 5'd0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b1);
        chk_all("mult.D", 1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
        adv();
        drv(1'b1, 5'd0, 3'd7, 5'd0, 3'd7, 5'd2, 1'b1, 3'd1, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("mflo.stall%0d", k), 32'(hif.stall_D), 32'd1);
            chk($sformatf("mflo.busy%0d", k), 32'(hif.md_busy), (k >= 1) ? 32'd1 : 32'd0);
            adv();
        end
        chk_all("mflo.go", 1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
        adv();
        flush();

        // div ; mult -> mult held 11 cycles, timer reloads 5
        drv(1'b1, 5'd4, 3'd1, 5'd5, 3'd1, 5'd0, 1'b0, 3'd0, 1'b1, 1'b1, 1'b1);
        adv();
        drv(1'b1, 5'd6, 3'd1, 5'd7, 3'd1, 5'd0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b1);
        for (int k = 0; k < 11; k++) begin
            chk($sformatf("mul.stall%0d", k), 32'(hif.stall_F), 32'd1);
            adv();
        end
        chk_all("mul.go", 1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
        adv();
        nop();
        chk({"mul.E", ".md_busy"}, 32'(hif.md_busy), 32'd0);
        adv();
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("mul.busy%0d", k), 32'(hif.md_busy), 32'd1);
            adv();
        end
        chk({"mul.done", ".md_busy"}, 32'(hif.md_busy), 32'd0);
        flush();

        // div in flight, 1-cycle reset -> timer and start discarded
        drv(1'b1, 5'd4, 3'd1, 5'd5, 3'd1, 5'd0, 1'b0, 3'd0, 1'b1, 1'b1, 1'b1);
        adv();
        nop();
        adv(); adv();
        chk({"div.fly", ".md_busy"}, 32'(hif.md_busy), 32'd1);
        reset = 1'b1;
        adv();
        reset = 1'b0;
        drv(1'b1, 5'd0, 3'd7, 5'd0, 3'd7, 5'd2, 1'b1, 3'd1, 1'b0, 1'b0, 1'b1);
        chk_all("rst.mid", 1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
        adv();
        nop();
        chk({"rst.after", ".md_busy"}, 32'(hif.md_busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
